// File: rtl/relm_uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter on a relm push channel.
// A FIFO absorbs CPU bursts; retry_out rejects pushes while the FIFO is full.
module relm_uart_tx_fifo #(
    parameter int WD    = 32,
    parameter int WFIFO = 4,
    parameter int DIV   = 434,
    parameter int NSTOP = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [WD:0]    push_d_in,
    output logic           retry_out,
    input  logic           cts_n_in,
    output logic           uart_out,
    output logic [WFIFO:0] level_out,
    output logic           busy_out
);

    localparam int DEPTH = 2 ** WFIFO;
    localparam int CW    = $clog2(NSTOP * DIV);
    localparam logic [CW-1:0] BIT_LD  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_LD = CW'(NSTOP * DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         r_state, w_state_nx;
    logic [7:0]     r_mem [DEPTH];
    logic [WFIFO-1:0] r_wptr, r_rptr;
    logic [WFIFO:0] r_level;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic [7:0]     r_sh, w_sh_nx;
    logic [2:0]     r_idx, w_idx_nx;
    logic           r_tx, w_tx_nx;
    logic           r_busy, w_busy_nx;
    logic [1:0]     r_cts_s;
    logic           w_full, w_accept, w_pop;
    logic           w_unused_bits;

    assign w_unused_bits = ^push_d_in[WD-1:8];

    // full is the registered occupancy, so a same-cycle pop never unblocks a push
    assign w_full    = (r_level == (WFIFO + 1)'(DEPTH));
    assign w_accept  = push_d_in[WD] && !w_full;
    assign retry_out = push_d_in[WD] && w_full;

    assign uart_out  = r_tx;
    assign level_out = r_level;
    assign busy_out  = r_busy;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_sh_nx    = r_sh;
        w_idx_nx   = r_idx;
        w_tx_nx    = r_tx;
        w_busy_nx  = r_busy;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != '0 && !r_cts_s[1]) begin
                    w_pop      = 1'b1;
                    w_sh_nx    = r_mem[r_rptr];
                    w_tx_nx    = 1'b0;
                    w_cnt_nx   = BIT_LD;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (r_cnt == '0) begin
                    w_tx_nx    = r_sh[0];
                    w_cnt_nx   = BIT_LD;
                    w_idx_nx   = '0;
                    w_state_nx = S_DATA;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == '0) begin
                    if (r_idx == 3'd7) begin
                        w_tx_nx    = 1'b1;
                        w_cnt_nx   = STOP_LD;
                        w_state_nx = S_STOP;
                    end else begin
                        w_sh_nx  = r_sh >> 1;
                        w_tx_nx  = r_sh[1];
                        w_idx_nx = r_idx + 3'd1;
                        w_cnt_nx = BIT_LD;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == '0) begin
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_cts_s <= 2'b11;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_sh    <= w_sh_nx;
            r_idx   <= w_idx_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
            r_cts_s <= {r_cts_s[0], cts_n_in};
            if (w_accept) r_wptr <= r_wptr + WFIFO'(1);
            if (w_pop)    r_rptr <= r_rptr + WFIFO'(1);
            r_level <= r_level + {{WFIFO{1'b0}}, w_accept} - {{WFIFO{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr] <= push_d_in[7:0];
    end

endmodule

// File: tb/tb_relm_uart_tx_fifo.sv
// Bench for relm_uart_tx_fifo: queue/frame-time model compared every cycle,
// a line decoder, and hand-computed literal expectations.
module tb_relm_uart_tx_fifo;

    localparam int WD    = 32;
    localparam int WFIFO = 2;
    localparam int DIV   = 4;
    localparam int NSTOP = 1;
    localparam int DEPTH = 2 ** WFIFO;
    localparam int FRAME = (9 + NSTOP) * DIV;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [WD:0]    push_d = '0;
    logic           cts_n = 1'b0;
    logic           retry_out;
    logic           uart_out;
    logic [WFIFO:0] level_out;
    logic           busy_out;

    int errors = 0;
    int checks = 0;
    bit ck_en  = 1'b0;

    relm_uart_tx_fifo #(.WD(WD), .WFIFO(WFIFO), .DIV(DIV), .NSTOP(NSTOP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_d_in (push_d),
        .retry_out (retry_out),
        .cts_n_in  (cts_n),
        .uart_out  (uart_out),
        .level_out (level_out),
        .busy_out  (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus "clocks since the current frame started".
    logic [7:0] m_q[$];
    bit         m_act = 1'b0;
    int         m_t = 0;
    logic [7:0] m_byte = '0;
    logic       m_s0 = 1'b1, m_s1 = 1'b1;
    bit         m_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_act = 1'b0;
            m_t   = 0;
            m_s0  = 1'b1;
            m_s1  = 1'b1;
        end else begin
            m_acc = push_d[WD] && (m_q.size() < DEPTH);
            if (m_act) begin
                m_t++;
                if (m_t == FRAME) m_act = 1'b0;
            end else if (m_q.size() != 0 && !m_s1) begin
                m_byte = m_q.pop_front();
                m_act  = 1'b1;
                m_t    = 0;
            end
            if (m_acc) m_q.push_back(push_d[7:0]);
            m_s1 = m_s0;
            m_s0 = cts_n;
        end
    end

    function automatic logic m_line();
        int k;
        if (!m_act) return 1'b1;
        k = m_t / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (ck_en) begin
            chk("uart_model",  {31'd0, uart_out},  {31'd0, m_line()});
            chk("busy_model",  {31'd0, busy_out},  {31'd0, m_act});
            chk("level_model", {29'd0, level_out}, m_q.size());
            chk("retry_model", {31'd0, retry_out}, {31'd0, push_d[WD] && (m_q.size() == DEPTH)});
        end
    end

    // Line decoder: samples each bit at its centre, independent of the model.
    logic [7:0] dq[$];
    logic       d_prev = 1'b1;
    logic [7:0] d_byte;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && d_prev && !uart_out) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    d_byte[i] = uart_out;
                end
                repeat (DIV) @(negedge clk);
                dq.push_back(d_byte);
            end
            d_prev = uart_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [7:0] b);
        push_d = {1'b1, 24'h0, b};
    endtask

    task automatic clr_push();
        push_d = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(busy_out == 1'b0 && level_out == '0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", budget);
        end
        repeat (2) step();
    endtask

    task automatic chk_dq(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, dq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < dq.size(); i++)
            chk(name, {24'd0, dq[i]}, {24'd0, exp[i]});
    endtask

    logic [9:0] exp1 = 10'b1010000010;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_uart",  {31'd0, uart_out},  32'd1);
        chk("rst_level", {29'd0, level_out}, 32'd0);
        chk("rst_busy",  {31'd0, busy_out},  32'd0);
        set_push(8'hAA);
        #1;
        chk("rst_retry", {31'd0, retry_out}, 32'd0);
        clr_push();
        #1 rst_n = 1'b1;
        step();
        ck_en = 1'b1;
        repeat (3) step();

        // 1: single byte 0x41
        set_push(8'h41);
        #1 chk("t1_retry", {31'd0, retry_out}, 32'd0);
        step();
        clr_push();
        chk("t1_level_after_push", {29'd0, level_out}, 32'd1);
        chk("t1_uart_still_idle",  {31'd0, uart_out},  32'd1);
        step();
        chk("t1_start_bit", {31'd0, uart_out}, 32'd0);
        chk("t1_busy",      {31'd0, busy_out}, 32'd1);
        repeat (2) step();
        chk("t1_bit0", {31'd0, uart_out}, {31'd0, exp1[0]});
        for (int k = 1; k < 10; k++) begin
            repeat (DIV) step();
            chk("t1_bit", {31'd0, uart_out}, {31'd0, exp1[k]});
        end
        repeat (2) step();
        chk("t1_busy_end",  {31'd0, busy_out},  32'd0);
        chk("t1_level_end", {29'd0, level_out}, 32'd0);
        wait_idle(100);

        // 2: fill to full with CTS held off
        dq.delete();
        cts_n = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            set_push(8'h10 + 8'(i));
            step();
        end
        clr_push();
        chk("t2_level_full", {29'd0, level_out}, 32'd4);
        set_push(8'h14);
        #1 chk("t2_retry", {31'd0, retry_out}, 32'd1);
        step();
        clr_push();
        chk("t2_level_hold", {29'd0, level_out}, 32'd4);
        chk("t2_no_tx",      {31'd0, busy_out},  32'd0);
        cts_n = 1'b0;
        wait_idle(400);
        chk_dq("t2_order", '{8'h10, 8'h11, 8'h12, 8'h13});

        // 3: back-to-back frames
        dq.delete();
        set_push(8'h00);
        step();
        set_push(8'hFF);
        step();
        clr_push();
        repeat (FRAME) step();
        chk("t3_gap_uart", {31'd0, uart_out}, 32'd1);
        chk("t3_gap_busy", {31'd0, busy_out}, 32'd0);
        step();
        chk("t3_second_start", {31'd0, uart_out}, 32'd0);
        wait_idle(200);
        chk_dq("t3_bytes", '{8'h00, 8'hFF});

        // 4: CTS deasserted mid-frame
        dq.delete();
        set_push(8'h5A);
        step();
        set_push(8'h33);
        step();
        clr_push();
        repeat (17) step();
        cts_n = 1'b1;
        begin
            int n = 0;
            while (busy_out && n < 100) begin step(); n++; end
        end
        repeat (20) step();
        chk("t4_held_busy",  {31'd0, busy_out},  32'd0);
        chk("t4_held_level", {29'd0, level_out}, 32'd1);
        chk("t4_held_uart",  {31'd0, uart_out},  32'd1);
        cts_n = 1'b0;
        repeat (2) step();
        chk("t4_sync_wait", {31'd0, uart_out}, 32'd1);
        step();
        chk("t4_resume", {31'd0, uart_out}, 32'd0);
        wait_idle(200);
        chk_dq("t4_bytes", '{8'h5A, 8'h33});

        // 5: push on the popping cycle
        dq.delete();
        set_push(8'h81);
        step();
        set_push(8'hC3);
        step();
        clr_push();
        chk("t5_level", {29'd0, level_out}, 32'd1);
        chk("t5_start", {31'd0, uart_out},  32'd0);
        wait_idle(200);
        chk_dq("t5_bytes", '{8'h81, 8'hC3});

        // 6: asynchronous reset mid-frame
        for (int i = 0; i < 4; i++) begin
            set_push(8'h01 + 8'(i));
            step();
        end
        clr_push();
        repeat (8) step();
        chk("t6_pre_level", {29'd0, level_out}, 32'd3);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_uart",  {31'd0, uart_out},  32'd1);
        chk("t6_rst_level", {29'd0, level_out}, 32'd0);
        chk("t6_rst_busy",  {31'd0, busy_out},  32'd0);
        #2 rst_n = 1'b1;
        step();
        repeat (60) step();
        chk("t6_idle_uart",  {31'd0, uart_out},  32'd1);
        chk("t6_idle_level", {29'd0, level_out}, 32'd0);

        ck_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
